rv32i_single_cycle_core: RTL and testbench
==========================================

Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I-subset processor with on-chip instruction and data memories; one instruction retires per rising clock edge.
- Integer top of the CPU: program counter, 32x32 register file, ALU, branch/jump unit, word-addressed IMEM/DMEM.
- Debug/load ports let a bench preload programs and observe architectural state without hierarchical references.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- imem_we  input  1  IMEM write enable, for program preload; may be used during reset.
- imem_waddr  input  32  IMEM byte address for preload, word index = addr[..:2].
- imem_wdata  input  32  IMEM preload data.
- dbg_reg_addr  input  5  register-file debug read index.
- dbg_reg_data  output  32  combinational value of x[dbg_reg_addr]; x0 reads 0.
- pc_o  output  32  current PC.
- instr_o  output  32  instruction at pc_o.
- reg_write_o  output  1  register writeback enable this cycle.
- halted_o  output  1  halt status; see Optional Feature.

Behaviour:
- Reset, asynchronous while reset=0: PC=RESET_PC, x1..x31=0, halted_o=0. Memories are not cleared. IMEM preload writes are honoured during reset.
- Each rising edge with reset=1:
  - PC <= pc_next.
  - rd <= writeback if reg_write and rd!=0.
  - DMEM word written for SW.
- IMEM and DMEM reads are combinational. Address index = byte_addr[log2(N)+1:2]; upper bits are ignored (wrap). addr[1:0] is ignored, so there is no misalignment trap.
- Supported instructions, all others are NOPs (no write, PC+4):
  - LUI, AUIPC.
  - JAL, JALR: rd = PC+4; JALR target = (rs1+imm) & ~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Immediates: I/S/B/U/J formats per RV32I, sign-extended; B and J offsets are shifted left by one.
- pc_next priority: JALR target, then JAL / taken-branch target PC+imm, else PC+4.
- Arithmetic is 32-bit modulo 2^32. Shifts use the low 5 bits of the shift amount. SLT is signed, SLTU is unsigned.
- Reading x0 always returns 0; writes to x0 are discarded.
- Same-cycle read and write of a register: the read returns the old value (single cycle, no forwarding needed).
- IMEM preload write concurrent with execution: the new word is visible next cycle.

Optional Feature:
- Macro HALT_ON_ECALL_EN.
- With the macro: instruction 32'h0000_0073 (ECALL) sets halted_o=1 on the next edge. While halted, PC freezes and no register or memory writes occur. Only reset clears the halt.
- Without the macro: ECALL is a NOP and halted_o is tied 0.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - funct3/funct7 constants;
  - ALU-operation enum (4 bits);
  - immediate-format enum.
- One natural sub-module: rv32_alu (a, b, op -> result, zero). Decode, register file and memories stay inline.

Test Plan:
- Reset and arithmetic: preload ADDI x4,x0,16; ADDI x1,x0,1; ADDI x2,x0,2; ADD x3,x1,x2; SUB x3,x2,x2; release reset. Required: x4=16, x1=1, x2=2, x3=3 after the 4th edge, then x3=0.
- Memory: SW x1,0(x4) then LW x5,0(x4). Required: DMEM word 4 = 1, x5=1.
- Upper immediates: LUI x5,0x1 gives x5=0x1000. AUIPC x5,0 at PC 0x20 gives x5=0x20.
- Branch: BEQ x3,x3,+8 at 0x24 (32'h00318463). Required: next PC=0x2C, ADDI x6 skipped (x6=0), ADDI x7,x0,2 executes (x7=2).
- Jump: JAL x1,+8 at 0x30. Required: x1=0x34, PC=0x38, x8=0, x9=4. Then x10=5 after ADDI at 0x3C.
- Edge cases:
  - ADDI x0,x0,5 leaves x0=0.
  - JALR x0,x1,1 with x1=0x34 jumps to 0x34.
  - Asserting reset mid-program returns PC to 0 and clears registers.
  - With HALT_ON_ECALL_EN, ECALL freezes pc_o and sets halted_o=1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and decode enums for the single-cycle core.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   // Major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD_SUB = 3'd0;
   localparam logic [2:0] F3_SLL     = 3'd1;
   localparam logic [2:0] F3_SLT     = 3'd2;
   localparam logic [2:0] F3_SLTU    = 3'd3;
   localparam logic [2:0] F3_XOR     = 3'd4;
   localparam logic [2:0] F3_SRL_SRA = 3'd5;
   localparam logic [2:0] F3_OR      = 3'd6;
   localparam logic [2:0] F3_AND     = 3'd7;

   // Branch / memory / jump funct3
   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;
   localparam logic [2:0] F3_LW   = 3'd2;
   localparam logic [2:0] F3_SW   = 3'd2;
   localparam logic [2:0] F3_JALR = 3'd0;

   // funct7
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

endpackage

// File: rtl/rv32_alu.sv
// 32-bit integer ALU; shifts use b[4:0], comparisons yield 0/1.
module rv32_alu
   import rv32_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     op,
   output logic [31:0] result,
   output logic        zero
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   // Operation select
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = 32'($signed(a) >>> shamt);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I-subset core with inline decode, register file, IMEM and DMEM.
// Optional build macro HALT_ON_ECALL_EN: ECALL halts the core until reset.
module rv32i_single_cycle_core
   import rv32_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        imem_we,
   input  logic [31:0] imem_waddr,
   input  logic [31:0] imem_wdata,
   input  logic [4:0]  dbg_reg_addr,
   output logic [31:0] dbg_reg_data,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        reg_write_o,
   output logic        halted_o
);

   localparam int unsigned IAW = $clog2(IMEM_WORDS);
   localparam int unsigned DAW = $clog2(DMEM_WORDS);

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] regs [32];

   logic [31:0] pc_q, pc_next, pc_plus4, pc_target;
   logic [31:0] instr, imm, rs1_val, rs2_val;
   logic [31:0] alu_a, alu_b, alu_result, wb_data, dmem_rdata;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic        alu_zero, branch_taken, run, rf_we;

   alu_op_e     alu_op;
   imm_fmt_e    imm_fmt;
   wb_sel_e     wb_sel;
   logic        a_sel_pc, a_sel_zero, b_sel_imm;
   logic        reg_write, mem_write, is_branch, is_jal, is_jalr;

   logic        unused_waddr_bits;
   assign unused_waddr_bits = ^{imem_waddr[31:IAW+2], imem_waddr[1:0]};

   assign instr  = imem[pc_q[IAW+1:2]];
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign rs1_val      = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val      = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : regs[dbg_reg_addr];

   // Immediate extraction, sign-extended; B/J offsets carry an implicit zero LSB
   always_comb begin
      imm = '0;
      case (imm_fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   // Main decode; anything not recognised falls through as a NOP
   always_comb begin
      alu_op     = ALU_ADD;
      imm_fmt    = IMM_I;
      wb_sel     = WB_ALU;
      a_sel_pc   = 1'b0;
      a_sel_zero = 1'b0;
      b_sel_imm  = 1'b1;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      is_branch  = 1'b0;
      is_jal     = 1'b0;
      is_jalr    = 1'b0;
      case (opcode)
         OPC_LUI: begin
            imm_fmt    = IMM_U;
            a_sel_zero = 1'b1;
            reg_write  = 1'b1;
         end
         OPC_AUIPC: begin
            imm_fmt   = IMM_U;
            a_sel_pc  = 1'b1;
            reg_write = 1'b1;
         end
         OPC_JAL: begin
            imm_fmt   = IMM_J;
            is_jal    = 1'b1;
            wb_sel    = WB_PC4;
            reg_write = 1'b1;
         end
         OPC_JALR: begin
            if (funct3 == F3_JALR) begin
               is_jalr   = 1'b1;
               wb_sel    = WB_PC4;
               reg_write = 1'b1;
            end
         end
         OPC_BRANCH: begin
            imm_fmt   = IMM_B;
            b_sel_imm = 1'b0;
            case (funct3)
               F3_BEQ, F3_BNE: begin
                  alu_op    = ALU_SUB;
                  is_branch = 1'b1;
               end
               F3_BLT, F3_BGE: begin
                  alu_op    = ALU_SLT;
                  is_branch = 1'b1;
               end
               F3_BLTU, F3_BGEU: begin
                  alu_op    = ALU_SLTU;
                  is_branch = 1'b1;
               end
               default: ;
            endcase
         end
         OPC_LOAD: begin
            if (funct3 == F3_LW) begin
               wb_sel    = WB_MEM;
               reg_write = 1'b1;
            end
         end
         OPC_STORE: begin
            if (funct3 == F3_SW) begin
               imm_fmt   = IMM_S;
               mem_write = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            reg_write = 1'b1;
            case (funct3)
               F3_ADD_SUB: alu_op = ALU_ADD;
               F3_SLT:     alu_op = ALU_SLT;
               F3_SLTU:    alu_op = ALU_SLTU;
               F3_XOR:     alu_op = ALU_XOR;
               F3_OR:      alu_op = ALU_OR;
               F3_AND:     alu_op = ALU_AND;
               F3_SLL: begin
                  if (funct7 == F7_BASE) alu_op = ALU_SLL;
                  else                   reg_write = 1'b0;
               end
               F3_SRL_SRA: begin
                  if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                  else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                  else                       reg_write = 1'b0;
               end
               default: reg_write = 1'b0;
            endcase
         end
         OPC_OP: begin
            b_sel_imm = 1'b0;
            reg_write = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
               {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
               {F7_BASE, F3_SLL}:     alu_op = ALU_SLL;
               {F7_BASE, F3_SLT}:     alu_op = ALU_SLT;
               {F7_BASE, F3_SLTU}:    alu_op = ALU_SLTU;
               {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
               {F7_BASE, F3_SRL_SRA}: alu_op = ALU_SRL;
               {F7_ALT,  F3_SRL_SRA}: alu_op = ALU_SRA;
               {F7_BASE, F3_OR}:      alu_op = ALU_OR;
               {F7_BASE, F3_AND}:     alu_op = ALU_AND;
               default:               reg_write = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   assign alu_a = a_sel_zero ? 32'd0 : (a_sel_pc ? pc_q : rs1_val);
   assign alu_b = b_sel_imm ? imm : rs2_val;

   rv32_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Branch resolution from the ALU compare result
   always_comb begin
      branch_taken = 1'b0;
      if (is_branch) begin
         case (funct3)
            F3_BEQ:           branch_taken = alu_zero;
            F3_BNE:           branch_taken = !alu_zero;
            F3_BLT, F3_BLTU:  branch_taken = alu_result[0];
            F3_BGE, F3_BGEU:  branch_taken = !alu_result[0];
            default:          branch_taken = 1'b0;
         endcase
      end
   end

   assign pc_plus4  = pc_q + 32'd4;
   assign pc_target = pc_q + imm;
   assign pc_next   = is_jalr                ? (alu_result & ~32'd1) :
                      (is_jal || branch_taken) ? pc_target : pc_plus4;

   assign dmem_rdata = dmem[alu_result[DAW+1:2]];

   // Writeback source select
   always_comb begin
      wb_data = alu_result;
      case (wb_sel)
         WB_MEM:  wb_data = dmem_rdata;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_result;
      endcase
   end

`ifdef HALT_ON_ECALL_EN
   logic halted_q;
   logic is_ecall;
   assign is_ecall = (instr == INSTR_ECALL);

   // Sticky halt flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        halted_q <= 1'b0;
      else if (is_ecall) halted_q <= 1'b1;
   end

   // The ECALL itself does not advance the PC, so pc_o stays on it
   assign run      = !halted_q && !is_ecall;
   assign halted_o = halted_q;
`else
   assign run      = 1'b1;
   assign halted_o = 1'b0;
`endif

   assign rf_we       = reg_write && run && (rd != 5'd0);
   assign reg_write_o = rf_we;
   assign pc_o        = pc_q;
   assign instr_o     = instr;

   // Program counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   pc_q <= RESET_PC;
      else if (run) pc_q <= pc_next;
   end

   // Register file; x0 is never written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rf_we) begin
         regs[rd] <= wb_data;
      end
   end

   // Instruction memory preload port, usable during reset
   always_ff @(posedge clk) begin
      if (imem_we) imem[imem_waddr[IAW+1:2]] <= imem_wdata;
   end

   // Data memory store
   always_ff @(posedge clk) begin
      if (reset && mem_write && run) dmem[alu_result[DAW+1:2]] <= rs2_val;
   end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: preloads programs, steps one edge at a
// time and checks register writeback, PC and writeback enable per step.
module tb_rv32i_single_cycle_core;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [31:0] npc;
      logic        we;
   } step_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic [4:0]  dbg_reg_addr;
   logic [31:0] dbg_reg_data;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        reg_write_o;
   logic        halted_o;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] img [40];
   step_t       steps1 [17];
   step_t       steps2 [25];
   step_t       exp_q [$];

   rv32i_single_cycle_core dut (
      .clk          (clk),
      .reset        (reset),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .dbg_reg_addr (dbg_reg_addr),
      .dbg_reg_data (dbg_reg_data),
      .pc_o         (pc_o),
      .instr_o      (instr_o),
      .reg_write_o  (reg_write_o),
      .halted_o     (halted_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Instruction encoders
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input int op);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                         input int f3);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input int f3);
      logic [31:0] v;
      v = 32'(imm);
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
      return {20'(imm20), 5'(rd), 7'(op)};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v;
      v = 32'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic read_reg(input int r, output logic [31:0] v);
      dbg_reg_addr = 5'(r);
      #1;
      v = dbg_reg_data;
   endtask

   task automatic load_img(input int n);
      for (int i = 0; i < n; i++) begin
         imem_we    = 1'b1;
         imem_waddr = 32'(i * 4);
         imem_wdata = img[i];
         @(posedge clk);
         #1;
      end
      imem_we = 1'b0;
   endtask

   // Push expectation, clock one edge, pop and compare
   task automatic run_step(input step_t s, input string tag);
      step_t       e;
      logic [31:0] v;
      exp_q.push_back(s);
      #1;
      chk({tag, " reg_write_o"}, 32'(reg_write_o), 32'(s.we));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      read_reg(int'(e.rd), v);
      chk($sformatf("%s x%0d", tag, e.rd), v, e.val);
      chk({tag, " pc_o"}, pc_o, e.npc);
   endtask

   initial begin
      logic [31:0] v;

      reset        = 1'b0;
      imem_we      = 1'b0;
      imem_waddr   = '0;
      imem_wdata   = '0;
      dbg_reg_addr = '0;

      // ---- program 1 ----
      img[0]  = enc_i(16, 0, 0, 4, 7'h13);
      img[1]  = enc_i(1, 0, 0, 1, 7'h13);
      img[2]  = enc_i(2, 0, 0, 2, 7'h13);
      img[3]  = enc_r(0, 2, 1, 0, 3);
      img[4]  = enc_r(32, 2, 2, 0, 3);
      img[5]  = enc_s(0, 1, 4, 2);
      img[6]  = enc_i(0, 4, 2, 5, 7'h03);
      img[7]  = enc_u(1, 5, 7'h37);
      img[8]  = enc_u(0, 5, 7'h17);
      img[9]  = 32'h0031_8463;
      img[10] = enc_i(1, 0, 0, 6, 7'h13);
      img[11] = enc_i(2, 0, 0, 7, 7'h13);
      img[12] = enc_j(8, 1);
      img[13] = enc_i(3, 0, 0, 8, 7'h13);
      img[14] = enc_i(4, 0, 0, 9, 7'h13);
      img[15] = enc_i(5, 0, 0, 10, 7'h13);
      img[16] = enc_i(5, 0, 0, 0, 7'h13);
      img[17] = enc_i(1, 1, 0, 0, 7'h67);

      steps1[0]  = '{5'd4,  32'd16,       32'h04, 1'b1};
      steps1[1]  = '{5'd1,  32'd1,        32'h08, 1'b1};
      steps1[2]  = '{5'd2,  32'd2,        32'h0C, 1'b1};
      steps1[3]  = '{5'd3,  32'd3,        32'h10, 1'b1};
      steps1[4]  = '{5'd3,  32'd0,        32'h14, 1'b1};
      steps1[5]  = '{5'd1,  32'd1,        32'h18, 1'b0};
      steps1[6]  = '{5'd5,  32'd1,        32'h1C, 1'b1};
      steps1[7]  = '{5'd5,  32'h1000,     32'h20, 1'b1};
      steps1[8]  = '{5'd5,  32'h20,       32'h24, 1'b1};
      steps1[9]  = '{5'd6,  32'd0,        32'h2C, 1'b0};
      steps1[10] = '{5'd7,  32'd2,        32'h30, 1'b1};
      steps1[11] = '{5'd1,  32'h34,       32'h38, 1'b1};
      steps1[12] = '{5'd9,  32'd4,        32'h3C, 1'b1};
      steps1[13] = '{5'd10, 32'd5,        32'h40, 1'b1};
      steps1[14] = '{5'd0,  32'd0,        32'h44, 1'b0};
      steps1[15] = '{5'd0,  32'd0,        32'h34, 1'b0};
      steps1[16] = '{5'd8,  32'd3,        32'h38, 1'b1};

      load_img(18);

      // Reset state
      chk("reset pc_o", pc_o, 32'h0);
      chk("reset halted_o", 32'(halted_o), 32'd0);
      chk("reset instr_o", instr_o, img[0]);
      read_reg(4, v);
      chk("reset x4", v, 32'd0);

      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         run_step(steps1[i], $sformatf("p1.%0d", i));
         if (i == 12) begin
            read_reg(8, v);
            chk("p1 x8 skipped by jal", v, 32'd0);
         end
      end
      read_reg(6, v);
      chk("p1 x6 skipped by beq", v, 32'd0);

      // Asynchronous reset mid-program
      #2;
      reset = 1'b0;
      #1;
      chk("midreset pc_o", pc_o, 32'h0);
      read_reg(1, v);
      chk("midreset x1", v, 32'd0);
      read_reg(10, v);
      chk("midreset x10", v, 32'd0);

      // ---- program 2 ----
      img[0]  = enc_u(32'h80000, 1, 7'h37);
      img[1]  = enc_i(-1, 0, 0, 2, 7'h13);
      img[2]  = enc_i(5, 0, 0, 3, 7'h13);
      img[3]  = enc_r(0, 2, 1, 2, 4);
      img[4]  = enc_r(0, 1, 2, 3, 4);
      img[5]  = enc_r(32, 3, 1, 5, 5);
      img[6]  = enc_r(0, 3, 1, 5, 5);
      img[7]  = enc_r(0, 3, 2, 1, 5);
      img[8]  = enc_i(32'hF0, 2, 4, 6, 7'h13);
      img[9]  = enc_i(32'h700, 3, 6, 6, 7'h13);
      img[10] = enc_i(-16, 2, 7, 6, 7'h13);
      img[11] = enc_i(-1, 3, 3, 7, 7'h13);
      img[12] = enc_i(-1, 3, 2, 7, 7'h13);
      img[13] = enc_i(32'h41F, 1, 5, 8, 7'h13);
      img[14] = enc_i(31, 1, 5, 8, 7'h13);
      img[15] = enc_i(30, 3, 1, 8, 7'h13);
      img[16] = enc_r(0, 1, 1, 0, 9);
      img[17] = enc_b(8, 3, 1, 4);
      img[18] = enc_i(7, 0, 0, 10, 7'h13);
      img[19] = enc_b(8, 3, 1, 6);
      img[20] = enc_b(8, 1, 3, 5);
      img[21] = enc_i(7, 0, 0, 10, 7'h13);
      img[22] = enc_b(8, 3, 3, 1);
      img[23] = enc_b(8, 1, 2, 7);
      img[24] = enc_i(7, 0, 0, 10, 7'h13);
      img[25] = enc_s(4, 2, 3, 2);
      img[26] = enc_i(8, 0, 2, 11, 7'h03);
      img[27] = enc_i(32'h108, 0, 2, 12, 7'h03);
      img[28] = 32'h0000_0073;
      img[29] = 32'hFFFF_FFFF;
      img[30] = enc_i(0, 0, 0, 0, 7'h13);

      steps2[0]  = '{5'd1,  32'h8000_0000, 32'h04, 1'b1};
      steps2[1]  = '{5'd2,  32'hFFFF_FFFF, 32'h08, 1'b1};
      steps2[2]  = '{5'd3,  32'd5,         32'h0C, 1'b1};
      steps2[3]  = '{5'd4,  32'd1,         32'h10, 1'b1};
      steps2[4]  = '{5'd4,  32'd0,         32'h14, 1'b1};
      steps2[5]  = '{5'd5,  32'hFC00_0000, 32'h18, 1'b1};
      steps2[6]  = '{5'd5,  32'h0400_0000, 32'h1C, 1'b1};
      steps2[7]  = '{5'd5,  32'hFFFF_FFE0, 32'h20, 1'b1};
      steps2[8]  = '{5'd6,  32'hFFFF_FF0F, 32'h24, 1'b1};
      steps2[9]  = '{5'd6,  32'h0000_0705, 32'h28, 1'b1};
      steps2[10] = '{5'd6,  32'hFFFF_FFF0, 32'h2C, 1'b1};
      steps2[11] = '{5'd7,  32'd1,         32'h30, 1'b1};
      steps2[12] = '{5'd7,  32'd0,         32'h34, 1'b1};
      steps2[13] = '{5'd8,  32'hFFFF_FFFF, 32'h38, 1'b1};
      steps2[14] = '{5'd8,  32'd1,         32'h3C, 1'b1};
      steps2[15] = '{5'd8,  32'h4000_0000, 32'h40, 1'b1};
      steps2[16] = '{5'd9,  32'd0,         32'h44, 1'b1};
      steps2[17] = '{5'd10, 32'd0,         32'h4C, 1'b0};
      steps2[18] = '{5'd10, 32'd0,         32'h50, 1'b0};
      steps2[19] = '{5'd10, 32'd0,         32'h58, 1'b0};
      steps2[20] = '{5'd10, 32'd0,         32'h5C, 1'b0};
      steps2[21] = '{5'd10, 32'd0,         32'h64, 1'b0};
      steps2[22] = '{5'd2,  32'hFFFF_FFFF, 32'h68, 1'b0};
      steps2[23] = '{5'd11, 32'hFFFF_FFFF, 32'h6C, 1'b1};
      steps2[24] = '{5'd12, 32'hFFFF_FFFF, 32'h70, 1'b1};

      load_img(31);
      reset = 1'b1;
      for (int i = 0; i < 25; i++) begin
         run_step(steps2[i], $sformatf("p2.%0d", i));
      end

`ifdef HALT_ON_ECALL_EN
      // ECALL freezes the core
      chk("ecall reg_write_o", 32'(reg_write_o), 32'd0);
      @(posedge clk);
      #1;
      chk("ecall halted_o", 32'(halted_o), 32'd1);
      chk("ecall pc_o", pc_o, 32'h70);
      repeat (3) @(posedge clk);
      #1;
      chk("halted pc_o frozen", pc_o, 32'h70);
      chk("halted reg_write_o", 32'(reg_write_o), 32'd0);
      read_reg(12, v);
      chk("halted x12", v, 32'hFFFF_FFFF);
      reset = 1'b0;
      #1;
      chk("halt cleared by reset", 32'(halted_o), 32'd0);
      chk("halt reset pc_o", pc_o, 32'h0);
`else
      // ECALL and an illegal word both behave as NOPs
      run_step('{5'd12, 32'hFFFF_FFFF, 32'h74, 1'b0}, "ecall-nop");
      chk("ecall-nop halted_o", 32'(halted_o), 32'd0);
      run_step('{5'd12, 32'hFFFF_FFFF, 32'h78, 1'b0}, "illegal-nop");

      // IMEM write while executing: visible on the following cycle
      imem_we    = 1'b1;
      imem_waddr = 32'h7C;
      imem_wdata = enc_i(9, 0, 0, 13, 7'h13);
      @(posedge clk);
      #1;
      imem_we = 1'b0;
      chk("live imem pc_o", pc_o, 32'h7C);
      chk("live imem instr_o", instr_o, enc_i(9, 0, 0, 13, 7'h13));
      run_step('{5'd13, 32'd9, 32'h80, 1'b1}, "live-imem");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
